// File: rtl/ser_ovs.sv
// ser_ovs: full-duplex oversampled async serial transceiver, LSB first, ready/valid transmit.
// Define SER_PARITY_EN to insert and check an even-parity bit after the payload.
module ser_ovs #(
   parameter int DATA_W    = 8,
   parameter int OVS       = 16,
   parameter int DIV       = 18,
   parameter int STOP_BITS = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              xmt_valid,
   input  logic [DATA_W-1:0] xmt_data,
   output logic              xmt_ready,
   output logic              xmt_done,
   output logic              sout,
   input  logic              sin,
   output logic              rcv_valid,
   output logic [DATA_W-1:0] rcv_data,
   output logic              rcv_frm_err,
   output logic              rcv_par_err,
   output logic              vld_str_deb
);

   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int OVS_W = $clog2(OVS);
   localparam int BIT_W = $clog2(DATA_W + 1);

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
   localparam logic [OVS_W-1:0] OVS_LAST  = OVS_W'(OVS - 1);
   localparam logic [OVS_W-1:0] OVS_MID   = OVS_W'(OVS / 2 - 1);
   localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
   localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
`ifdef SER_PARITY_EN
      TX_PARITY,
`endif
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
`ifdef SER_PARITY_EN
      RX_PARITY,
`endif
      RX_STOP,
      RX_WAIT_HI
   } rx_state_t;

   logic [DIV_W-1:0] div_cnt;
   logic             tick;

   assign tick = (div_cnt == DIV_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n)
         div_cnt <= '0;
      else if (tick)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + 1'b1;
   end

   tx_state_t         tx_state;
   logic [DATA_W-1:0] tx_shift;
   logic [OVS_W-1:0]  tx_cnt;
   logic [BIT_W-1:0]  tx_bit;
   logic              tx_armed;
   logic              tx_bit_end;
`ifdef SER_PARITY_EN
   logic              tx_par;
`endif

   assign tx_bit_end = tick && tx_armed && (tx_cnt == OVS_LAST);

   // The start bit is only put on the line at the first tick after the handshake,
   // so every bit, including the start bit, lasts exactly OVS ticks.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_state  <= TX_IDLE;
         tx_shift  <= '0;
         tx_cnt    <= '0;
         tx_bit    <= '0;
         tx_armed  <= 1'b0;
         xmt_ready <= 1'b1;
         xmt_done  <= 1'b0;
         sout      <= 1'b1;
`ifdef SER_PARITY_EN
         tx_par    <= 1'b0;
`endif
      end else begin
         xmt_done <= 1'b0;
         if (tick && tx_armed)
            tx_cnt <= (tx_cnt == OVS_LAST) ? '0 : tx_cnt + 1'b1;
         case (tx_state)
            TX_IDLE: begin
               if (xmt_valid) begin
                  tx_shift  <= xmt_data;
                  tx_cnt    <= '0;
                  tx_armed  <= 1'b0;
                  xmt_ready <= 1'b0;
                  tx_state  <= TX_START;
`ifdef SER_PARITY_EN
                  tx_par    <= ^xmt_data;
`endif
               end
            end
            TX_START: begin
               if (tick && !tx_armed) begin
                  sout     <= 1'b0;
                  tx_armed <= 1'b1;
               end else if (tx_bit_end) begin
                  sout     <= tx_shift[0];
                  tx_bit   <= '0;
                  tx_state <= TX_DATA;
               end
            end
            TX_DATA: begin
               if (tx_bit_end) begin
                  tx_shift <= tx_shift >> 1;
                  if (tx_bit == DATA_LAST) begin
                     tx_bit <= '0;
`ifdef SER_PARITY_EN
                     sout     <= tx_par;
                     tx_state <= TX_PARITY;
`else
                     sout     <= 1'b1;
                     tx_state <= TX_STOP;
`endif
                  end else begin
                     tx_bit <= tx_bit + 1'b1;
                     sout   <= tx_shift[1];
                  end
               end
            end
`ifdef SER_PARITY_EN
            TX_PARITY: begin
               if (tx_bit_end) begin
                  sout     <= 1'b1;
                  tx_state <= TX_STOP;
               end
            end
`endif
            TX_STOP: begin
               if (tx_bit_end) begin
                  if (tx_bit == STOP_LAST) begin
                     xmt_done  <= 1'b1;
                     xmt_ready <= 1'b1;
                     tx_armed  <= 1'b0;
                     tx_state  <= TX_IDLE;
                  end else begin
                     tx_bit <= tx_bit + 1'b1;
                  end
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   logic sin_m, sin_s;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sin_m <= 1'b1;
         sin_s <= 1'b1;
      end else begin
         sin_m <= sin;
         sin_s <= sin_m;
      end
   end

   rx_state_t         rx_state;
   logic [OVS_W-1:0]  rx_cnt;
   logic [BIT_W-1:0]  rx_bit;
   logic [DATA_W-1:0] rx_shift;
   logic              rx_sample;
`ifdef SER_PARITY_EN
   logic              rx_par_bad;
`endif

   assign rx_sample = tick && (rx_cnt == OVS_LAST);

   // Every sample point resets the tick count, so later samples land OVS ticks
   // apart at bit centres; a break line parks in RX_WAIT_HI after one error.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_state    <= RX_IDLE;
         rx_cnt      <= '0;
         rx_bit      <= '0;
         rx_shift    <= '0;
         rcv_data    <= '0;
         rcv_valid   <= 1'b0;
         rcv_frm_err <= 1'b0;
         vld_str_deb <= 1'b0;
`ifdef SER_PARITY_EN
         rx_par_bad  <= 1'b0;
         rcv_par_err <= 1'b0;
`endif
      end else begin
         rcv_valid   <= 1'b0;
         rcv_frm_err <= 1'b0;
`ifdef SER_PARITY_EN
         rcv_par_err <= 1'b0;
`endif
         if (tick && rx_state != RX_IDLE && rx_state != RX_WAIT_HI)
            rx_cnt <= rx_cnt + 1'b1;
         case (rx_state)
            RX_IDLE: begin
               if (tick && !sin_s) begin
                  rx_cnt   <= '0;
                  rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (tick && rx_cnt == OVS_MID) begin
                  rx_cnt <= '0;
                  if (sin_s) begin
                     rx_state <= RX_IDLE;
                  end else begin
                     vld_str_deb <= 1'b1;
                     rx_bit      <= '0;
                     rx_state    <= RX_DATA;
                  end
               end
            end
            RX_DATA: begin
               if (rx_sample) begin
                  rx_cnt   <= '0;
                  rx_shift <= {sin_s, rx_shift[DATA_W-1:1]};
                  if (rx_bit == DATA_LAST) begin
`ifdef SER_PARITY_EN
                     rx_state <= RX_PARITY;
`else
                     rx_state <= RX_STOP;
`endif
                  end else begin
                     rx_bit <= rx_bit + 1'b1;
                  end
               end
            end
`ifdef SER_PARITY_EN
            RX_PARITY: begin
               if (rx_sample) begin
                  rx_cnt     <= '0;
                  rx_par_bad <= sin_s ^ (^rx_shift);
                  rx_state   <= RX_STOP;
               end
            end
`endif
            RX_STOP: begin
               if (rx_sample) begin
                  rx_cnt   <= '0;
                  rcv_data <= rx_shift;
`ifdef SER_PARITY_EN
                  rcv_par_err <= rx_par_bad;
`endif
                  if (sin_s) begin
                     rcv_valid <= 1'b1;
                     rx_state  <= RX_IDLE;
                  end else begin
                     rcv_frm_err <= 1'b1;
                     rx_state    <= RX_WAIT_HI;
                  end
               end
            end
            RX_WAIT_HI: begin
               if (tick && sin_s)
                  rx_state <= RX_IDLE;
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

`ifndef SER_PARITY_EN
   assign rcv_par_err = 1'b0;
`endif

endmodule

// File: tb/tb_ser_ovs.sv
// tb_ser_ovs: self-checking bench for ser_ovs against a frame-level line model.
// Builds with or without SER_PARITY_EN; the parity scenario runs only when it is defined.
`timescale 1ns/1ps
module tb_ser_ovs;

   localparam int DATA_W    = 8;
   localparam int OVS       = 4;
   localparam int DIV       = 3;
   localparam int STOP_BITS = 1;
   localparam int BP        = OVS * DIV;
`ifdef SER_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int NBITS = 1 + DATA_W + PAR + STOP_BITS;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              xmt_valid = 1'b0;
   logic [DATA_W-1:0] xmt_data = '0;
   logic              sin_drv = 1'b1;
   logic              loop_en = 1'b0;
   logic              xmt_ready, xmt_done, sout, sin;
   logic              rcv_valid, rcv_frm_err, rcv_par_err, vld_str_deb;
   logic [DATA_W-1:0] rcv_data;

   assign sin = loop_en ? sout : sin_drv;

   ser_ovs #(.DATA_W(DATA_W), .OVS(OVS), .DIV(DIV), .STOP_BITS(STOP_BITS)) dut (
      .clk(clk), .rst_n(rst_n),
      .xmt_valid(xmt_valid), .xmt_data(xmt_data), .xmt_ready(xmt_ready),
      .xmt_done(xmt_done), .sout(sout), .sin(sin),
      .rcv_valid(rcv_valid), .rcv_data(rcv_data), .rcv_frm_err(rcv_frm_err),
      .rcv_par_err(rcv_par_err), .vld_str_deb(vld_str_deb)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got === exp)
         passes++;
      else
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
   endtask

   // Line model: edge_n counts rising edges since reset release, which fixes the tick phase.
   int                edge_n = 0;
   logic              h1 = 1'b1, h2 = 1'b1;
   bit                model_live = 0;
   bit                tx_busy = 0, hs_seen = 0;
   int                tx_e0, tx_end;
   logic              tx_bits [0:15];
   int                rx_mode = 0;
   int                rx_det;
   logic [DATA_W-1:0] rx_word = '0;
   logic              rx_par_s = 1'b0;
   logic              exp_sout = 1'b1, exp_ready = 1'b1, exp_done = 1'b0;
   logic              exp_valid = 1'b0, exp_frm = 1'b0, exp_par = 1'b0, exp_deb = 1'b0;
   logic [DATA_W-1:0] exp_data = '0;

   always @(posedge clk) begin : model
      bit   tk;
      logic s;
      int   off, idx;
      if (!rst_n) begin
         edge_n = 0; h1 = 1'b1; h2 = 1'b1;
         tx_busy = 0; rx_mode = 0;
         exp_sout = 1'b1; exp_ready = 1'b1; exp_done = 1'b0;
         exp_valid = 1'b0; exp_frm = 1'b0; exp_par = 1'b0;
         exp_data = '0; exp_deb = 1'b0;
         model_live = 1;
      end else begin
         tk = (edge_n % DIV) == DIV - 1;
         s  = h2;
         h2 = h1;
         h1 = sin;
         exp_done = 1'b0;
         if (!tx_busy && xmt_valid) begin
            tx_busy = 1;
            hs_seen = 1;
            tx_e0 = edge_n + 1;
            while (tx_e0 % DIV != DIV - 1) tx_e0++;
            tx_end = tx_e0 + NBITS * BP;
            tx_bits[0] = 1'b0;
            for (int i = 0; i < DATA_W; i++) tx_bits[1 + i] = xmt_data[i];
            if (PAR == 1) tx_bits[1 + DATA_W] = ^xmt_data;
            for (int i = 0; i < STOP_BITS; i++) tx_bits[1 + DATA_W + PAR + i] = 1'b1;
         end else if (tx_busy && edge_n == tx_end) begin
            tx_busy = 0;
            exp_done = 1'b1;
         end
         exp_ready = !tx_busy;
         exp_sout  = (tx_busy && edge_n >= tx_e0) ? tx_bits[(edge_n - tx_e0) / BP] : 1'b1;

         exp_valid = 1'b0; exp_frm = 1'b0; exp_par = 1'b0;
         case (rx_mode)
            0: if (tk && !s) begin rx_mode = 1; rx_det = edge_n; end
            1: begin
               off = edge_n - rx_det - (OVS / 2) * DIV;
               if (off >= 0 && off % BP == 0) begin
                  idx = off / BP;
                  if (idx == 0) begin
                     if (s) rx_mode = 0;
                     else exp_deb = 1'b1;
                  end else if (idx <= DATA_W) begin
                     rx_word[idx - 1] = s;
                  end else if (idx == DATA_W + 1 && PAR == 1) begin
                     rx_par_s = s;
                  end else begin
                     exp_data = rx_word;
                     exp_par  = (PAR == 1) && (rx_par_s != ^rx_word);
                     if (s) begin exp_valid = 1'b1; rx_mode = 0; end
                     else begin exp_frm = 1'b1; rx_mode = 2; end
                  end
               end
            end
            default: if (tk && s) rx_mode = 0;
         endcase
         edge_n++;
      end
   end

   int                n_valid = 0, n_frm = 0, n_par = 0, n_done = 0, n_vp = 0;
   logic [DATA_W-1:0] got_q [$];

   always @(negedge clk) begin : compare
      if (model_live) begin
         checkOutput("sout", sout, exp_sout);
         checkOutput("xmt_ready", xmt_ready, exp_ready);
         checkOutput("xmt_done", xmt_done, exp_done);
         checkOutput("rcv_valid", rcv_valid, exp_valid);
         checkOutput("rcv_data", rcv_data, exp_data);
         checkOutput("rcv_frm_err", rcv_frm_err, exp_frm);
         checkOutput("rcv_par_err", rcv_par_err, exp_par);
         checkOutput("vld_str_deb", vld_str_deb, exp_deb);
         if (rcv_valid === 1'b1) begin n_valid++; got_q.push_back(rcv_data); end
         if (rcv_frm_err === 1'b1) n_frm++;
         if (rcv_par_err === 1'b1) n_par++;
         if (rcv_par_err === 1'b1 && rcv_valid === 1'b1) n_vp++;
         if (xmt_done === 1'b1) n_done++;
      end
   end

   task automatic holdSin(input logic v, input int n);
      sin_drv = v;
      repeat (n) @(negedge clk);
   endtask

   // Drives one frame onto sin from the bench, optionally with bad stop/parity and a trailing break.
   task automatic applyStimulus(input logic [DATA_W-1:0] d, input logic stop_v,
                                input logic par_flip, input int extra_low);
      @(negedge clk);
      holdSin(1'b0, BP);
      for (int i = 0; i < DATA_W; i++) holdSin(d[i], BP);
      if (PAR == 1) holdSin(^d ^ par_flip, BP);
      holdSin(stop_v, BP);
      if (extra_low > 0) holdSin(1'b0, extra_low);
      sin_drv = 1'b1;
   endtask

   task automatic sendTx(input logic [DATA_W-1:0] d);
      int n = 0;
      @(negedge clk);
      xmt_data  = d;
      xmt_valid = 1'b1;
      hs_seen   = 0;
      while (!hs_seen && n < 4 * NBITS * BP) begin @(negedge clk); n++; end
      xmt_valid = 1'b0;
      checkOutput("tx_handshake", hs_seen, 1);
   endtask

   task automatic waitTxIdle();
      int n = 0;
      while (xmt_ready !== 1'b1 && n < 2 * NBITS * BP) begin @(negedge clk); n++; end
      checkOutput("tx_idle_wait", xmt_ready, 1);
   endtask

   initial begin : watchdog
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : directed
      int n, nv, nf, np, nd, nvp;
      logic [11:0] pat;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_sout", sout, 1);
      checkOutput("reset_ready", xmt_ready, 1);
      checkOutput("reset_rcv_data", rcv_data, 0);
      checkOutput("reset_pulses", {xmt_done, rcv_valid, rcv_frm_err, rcv_par_err}, 0);
      checkOutput("reset_deb", vld_str_deb, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      $display("[TB] transmit 0xA5");
`ifdef SER_PARITY_EN
      pat = 12'b010100101010;
`else
      pat = 12'b010100101100;
`endif
      sendTx(8'hA5);
      n = 0;
      while (sout !== 1'b0 && n < DIV + 2) begin @(negedge clk); n++; end
      checkOutput("tx_start_latency", (n >= 1 && n <= DIV), 1);
      repeat (BP / 2) @(negedge clk);
      for (int i = 0; i < NBITS; i++) begin
         checkOutput("tx_bit_pattern", sout, pat[11 - i]);
         if (i < NBITS - 1) repeat (BP) @(negedge clk);
      end
      n = BP / 2 + (NBITS - 1) * BP;
      while (xmt_done !== 1'b1 && n < NBITS * BP + 4 * DIV) begin @(negedge clk); n++; end
      checkOutput("tx_done_delay", n, NBITS * BP);
      @(negedge clk);
      checkOutput("tx_done_one_cycle", xmt_done, 0);
      checkOutput("tx_ready_back", xmt_ready, 1);

      $display("[TB] start glitch");
      nv = n_valid; nf = n_frm;
      holdSin(1'b0, 4);
      holdSin(1'b1, 3 * BP);
      checkOutput("glitch_no_valid", n_valid - nv, 0);
      checkOutput("glitch_no_err", n_frm - nf, 0);
      checkOutput("glitch_deb", vld_str_deb, 0);

      $display("[TB] loopback back-to-back");
      got_q.delete();
      nv = n_valid; nf = n_frm;
      loop_en = 1'b1;
      sendTx(8'h3C);
      sendTx(8'hC3);
      waitTxIdle();
      repeat (2 * BP) @(negedge clk);
      loop_en = 1'b0;
      checkOutput("loop_valid_count", n_valid - nv, 2);
      checkOutput("loop_data0", got_q.size() > 0 ? got_q[0] : 8'hxx, 8'h3C);
      checkOutput("loop_data1", got_q.size() > 1 ? got_q[1] : 8'hxx, 8'hC3);
      checkOutput("loop_deb", vld_str_deb, 1);
      checkOutput("loop_no_err", n_frm - nf, 0);

      $display("[TB] framing error and break");
      nv = n_valid; nf = n_frm;
      applyStimulus(8'h55, 1'b0, 1'b0, 200);
      holdSin(1'b1, 2 * BP);
      checkOutput("break_one_err", n_frm - nf, 1);
      checkOutput("break_no_valid", n_valid - nv, 0);
      checkOutput("break_data", rcv_data, 8'h55);
      applyStimulus(8'hA3, 1'b1, 1'b0, 0);
      holdSin(1'b1, 2 * BP);
      checkOutput("after_break_valid", n_valid - nv, 1);
      checkOutput("after_break_data", rcv_data, 8'hA3);
      checkOutput("after_break_err", n_frm - nf, 1);

`ifdef SER_PARITY_EN
      $display("[TB] parity");
      sendTx(8'h07);
      n = 0;
      while (sout !== 1'b0 && n < DIV + 2) begin @(negedge clk); n++; end
      repeat (BP / 2 + DATA_W * BP) @(negedge clk);
      checkOutput("tx_parity_bit", sout, 1);
      waitTxIdle();
      nv = n_valid; np = n_par; nvp = n_vp;
      applyStimulus(8'h07, 1'b1, 1'b1, 0);
      holdSin(1'b1, 2 * BP);
      checkOutput("par_err_count", n_par - np, 1);
      checkOutput("par_valid_count", n_valid - nv, 1);
      checkOutput("par_together", n_vp - nvp, 1);
      checkOutput("par_data", rcv_data, 8'h07);
`endif

      $display("[TB] reset mid-frame");
      nv = n_valid; nd = n_done;
      loop_en = 1'b1;
      sendTx(8'h96);
      repeat (5 * BP) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (NBITS * BP + 2 * BP) @(negedge clk);
      loop_en = 1'b0;
      checkOutput("abort_no_done", n_done - nd, 0);
      checkOutput("abort_no_valid", n_valid - nv, 0);
      checkOutput("abort_sout", sout, 1);
      checkOutput("abort_ready", xmt_ready, 1);
      checkOutput("abort_deb_cleared", vld_str_deb, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
